// File: rtl/tone_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tone_gen
//  Purpose  : Multi-channel PWM tone generator. Each channel plays a note with
//             a programmable period, duty and duration (in prescaled ticks).
//             It reports per-channel busy and done status, and drives a mixed
//             buzzer output.
//  Revision : 1.0 - initial multi-channel release
// ============================================================================
module tone_gen #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int TICK_HZ  = 1000,
    parameter int CHANNELS = 2,
    parameter int CHW      = 1,
    parameter int PW       = 32,
    parameter int DW       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [CHW-1:0]      wr_ch,
    input  logic [PW-1:0]       wr_period,
    input  logic [PW-1:0]       wr_duty,
    input  logic [DW-1:0]       wr_dur,
    input  logic [CHANNELS-1:0] stop_mask,
    output logic [CHANNELS-1:0] tone,
    output logic                mix,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] done
);

    localparam int c_TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int c_PRE_W    = (c_TICK_DIV > 1) ? $clog2(c_TICK_DIV) : 1;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_PLAY = 1'b1;

    logic [c_PRE_W-1:0]  r_pre;
    logic                w_tick;
    logic [CHANNELS-1:0] w_tone_next;
    logic                r_mix;

    // The tick marks the last count of the prescaler period.
    assign w_tick = (r_pre == c_PRE_W'(c_TICK_DIV - 1));

    // The shared prescaler runs freely. Writes never restart it, so every
    // channel sees the same tick grid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + c_PRE_W'(1);
        end
    end

    // Mix registers the OR of the tone values that the channels load at the
    // same edge, so mix(t) always equals |tone(t).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mix <= 1'b0;
        end else begin
            r_mix <= |w_tone_next;
        end
    end

    assign mix = r_mix;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic [0:0]    r_state;
        logic [0:0]    w_state_n;
        logic [PW-1:0] r_period;
        logic [PW-1:0] w_period_n;
        logic [PW-1:0] r_duty;
        logic [PW-1:0] w_duty_n;
        logic [PW-1:0] r_phase;
        logic [PW-1:0] w_phase_n;
        logic [DW-1:0] r_dur;
        logic [DW-1:0] w_dur_n;
        logic          r_tone;
        logic          w_tone_n;
        logic          r_busy;
        logic          r_done;
        logic          w_done_n;
        logic          w_wr;
        logic          w_stop;
        logic          w_last;
        logic          w_expire;

        // Channel indices at or above CHANNELS have no matching channel,
        // so those writes are dropped.
        assign w_wr     = wr_en && (wr_ch == CHW'(gi));
        assign w_stop   = stop_mask[gi];
        assign w_last   = (r_phase == (r_period - PW'(1)));
        assign w_expire = w_tick && (r_dur == DW'(1));

        // Next-state decode. Priority is write, then stop, then expiry or
        // the normal phase advance.
        always_comb begin
            w_state_n  = r_state;
            w_period_n = r_period;
            w_duty_n   = r_duty;
            w_phase_n  = r_phase;
            w_dur_n    = r_dur;
            w_tone_n   = 1'b0;
            w_done_n   = 1'b0;
            if (w_wr) begin
                if (wr_period < PW'(2)) begin
                    // A period below 2 cannot form a tone, so it acts as a stop.
                    w_state_n = c_ST_IDLE;
                    w_phase_n = '0;
                    w_dur_n   = '0;
                end else begin
                    w_state_n  = c_ST_PLAY;
                    w_period_n = wr_period;
                    w_duty_n   = wr_duty;
                    w_dur_n    = wr_dur;
                    w_phase_n  = '0;
                    w_tone_n   = (wr_duty != '0);
                end
            end else if (w_stop) begin
                w_state_n = c_ST_IDLE;
                w_phase_n = '0;
                w_dur_n   = '0;
            end else if (r_state == c_ST_PLAY) begin
                if (w_expire) begin
                    w_state_n = c_ST_IDLE;
                    w_phase_n = '0;
                    w_dur_n   = '0;
                    w_done_n  = 1'b1;
                end else begin
                    // A zero duration means the note plays until stopped.
                    if (w_tick && (r_dur != '0)) begin
                        w_dur_n = r_dur - DW'(1);
                    end
                    w_phase_n = w_last ? '0 : (r_phase + PW'(1));
                    w_tone_n  = (w_phase_n < r_duty);
                end
            end
        end

        // Channel state and registered outputs.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_state  <= c_ST_IDLE;
                r_period <= '0;
                r_duty   <= '0;
                r_phase  <= '0;
                r_dur    <= '0;
                r_tone   <= 1'b0;
                r_busy   <= 1'b0;
                r_done   <= 1'b0;
            end else begin
                r_state  <= w_state_n;
                r_period <= w_period_n;
                r_duty   <= w_duty_n;
                r_phase  <= w_phase_n;
                r_dur    <= w_dur_n;
                r_tone   <= w_tone_n;
                r_busy   <= (w_state_n == c_ST_PLAY);
                r_done   <= w_done_n;
            end
        end

        assign w_tone_next[gi] = w_tone_n;
        assign tone[gi]        = r_tone;
        assign busy[gi]        = r_busy;
        assign done[gi]        = r_done;
    end

endmodule
`default_nettype wire

// File: tb/tb_tone_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_tone_gen
//  Purpose  : Self-checking bench for tone_gen. It compares the design against
//             a note-level reference model that tracks the elapsed cycles of
//             each note and the remaining ticks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tone_gen;

    localparam int c_TICK_DIV = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [1:0] wr_ch;
    logic [7:0] wr_period;
    logic [7:0] wr_duty;
    logic [7:0] wr_dur;
    logic [1:0] stop_mask;
    logic [1:0] tone;
    logic       mix;
    logic [1:0] busy;
    logic [1:0] done;

    int total = 0;
    int bad   = 0;

    // Reference model: the prescaler position, and for each channel whether
    // a note is active, its parameters, the ticks left and the cycles elapsed.
    int m_pre;
    bit m_act  [2];
    int m_p    [2];
    int m_d    [2];
    int m_rem  [2];
    int m_k    [2];
    bit m_done [2];

    tone_gen #(
        .CLK_HZ  (1000),
        .TICK_HZ (100),
        .CHANNELS(2),
        .CHW     (2),
        .PW      (8),
        .DW      (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_ch    (wr_ch),
        .wr_period(wr_period),
        .wr_duty  (wr_duty),
        .wr_dur   (wr_dur),
        .stop_mask(stop_mask),
        .tone     (tone),
        .mix      (mix),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        assert (act === exp) else begin
            bad++;
            $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, act, exp);
        end
    endtask

    // Drive one cycle of inputs, update the model at the edge and check all outputs.
    task automatic step(input bit r, input bit w, input int ch, input int p, input int d,
                        input int du, input logic [1:0] stp);
        bit         tick;
        logic [1:0] e_tone;
        logic [1:0] e_busy;
        logic [1:0] e_done;
        rst       = r;
        wr_en     = w;
        wr_ch     = ch[1:0];
        wr_period = p[7:0];
        wr_duty   = d[7:0];
        wr_dur    = du[7:0];
        stop_mask = stp;
        @(posedge clk);
        if (r) begin
            m_pre = 0;
            for (int c = 0; c < 2; c++) begin
                m_act[c]  = 0;
                m_done[c] = 0;
            end
        end else begin
            tick  = (m_pre == c_TICK_DIV - 1);
            m_pre = (m_pre + 1) % c_TICK_DIV;
            for (int c = 0; c < 2; c++) begin
                m_done[c] = 0;
                if (w && ch == c) begin
                    if (p < 2) begin
                        m_act[c] = 0;
                    end else begin
                        m_act[c] = 1;
                        m_p[c]   = p;
                        m_d[c]   = d;
                        m_rem[c] = du;
                        m_k[c]   = 0;
                    end
                end else if (stp[c]) begin
                    m_act[c] = 0;
                end else if (m_act[c]) begin
                    m_k[c]++;
                    if (tick && m_rem[c] != 0) begin
                        m_rem[c]--;
                        if (m_rem[c] == 0) begin
                            m_act[c]  = 0;
                            m_done[c] = 1;
                        end
                    end
                end
            end
        end
        for (int c = 0; c < 2; c++) begin
            e_tone[c] = m_act[c] ? ((m_k[c] % m_p[c]) < m_d[c]) : 1'b0;
            e_busy[c] = m_act[c];
            e_done[c] = m_done[c];
        end
        #1;
        chk("tone", {30'd0, tone}, {30'd0, e_tone});
        chk("mix",  {31'd0, mix},  {31'd0, |e_tone});
        chk("busy", {30'd0, busy}, {30'd0, e_busy});
        chk("done", {30'd0, done}, {30'd0, e_done});
        rst       = 1'b0;
        wr_en     = 1'b0;
        stop_mask = 2'b00;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 2'b00);
    endtask

    task automatic wr(input int ch, input int p, input int d, input int du);
        step(0, 1, ch, p, d, du, 2'b00);
    endtask

    // Idle until the next edge is a tick edge (bounded by one prescaler period).
    task automatic align_tick();
        for (int i = 0; i < c_TICK_DIV && m_pre != c_TICK_DIV - 1; i++) idle(1);
    endtask

    initial begin
        int bc;
        int dc0;
        int dc1;
        rst = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_period = '0;
        wr_duty = '0; wr_dur = '0; stop_mask = '0;

        // Reset with wr_en held high, then release and stay idle.
        for (int i = 0; i < 3; i++) step(1, 1, 0, 4, 2, 3, 2'b00);
        idle(5);

        // Basic note, written so that the prescaler reads 0 right after the write.
        align_tick();
        wr(0, 4, 1, 3);
        bc  = busy[0];
        dc0 = 0;
        for (int i = 0; i < 35; i++) begin
            idle(1);
            bc  += busy[0];
            dc0 += done[0];
        end
        chk("basic_busy_cycles", bc, 30);
        chk("basic_done_pulses", dc0, 1);

        // Duty extremes and an endless note.
        wr(0, 5, 0, 2);
        idle(25);
        wr(0, 5, 9, 0);
        dc0 = 0;
        for (int i = 0; i < 300; i++) begin
            idle(1);
            dc0 += done[0];
        end
        chk("endless_no_done", dc0, 0);

        // Retrigger into a fast toggle, then stop.
        wr(0, 6, 3, 5);
        idle(7);
        wr(0, 2, 1, 0);
        idle(10);
        step(0, 0, 0, 0, 0, 0, 2'b01);
        chk("stop_busy0", {31'd0, busy[0]}, 32'd0);
        idle(3);

        // Two channels together.
        wr(0, 4, 2, 2);
        wr(1, 6, 1, 4);
        dc0 = 0;
        dc1 = 0;
        for (int i = 0; i < 50; i++) begin
            idle(1);
            dc0 += done[0];
            dc1 += done[1];
        end
        chk("two_done0", dc0, 1);
        chk("two_done1", dc1, 1);

        // A write lands on the expiry tick of ch1.
        wr(1, 3, 1, 1);
        align_tick();
        wr(1, 4, 2, 2);
        chk("collide_no_done", {31'd0, done[1]}, 32'd0);
        chk("collide_busy",    {31'd0, busy[1]}, 32'd1);
        idle(4);

        // A write and a stop to ch1 in the same cycle: the write wins.
        step(0, 1, 1, 5, 2, 0, 2'b10);
        chk("wr_beats_stop", {31'd0, busy[1]}, 32'd1);
        idle(4);

        // A write with period 1 acts as a stop.
        wr(1, 1, 1, 0);
        chk("period1_idle", {31'd0, busy[1]}, 32'd0);

        // An out-of-range channel index is ignored.
        wr(3, 4, 2, 0);
        chk("ch3_ignored", {30'd0, busy}, 32'd0);
        idle(3);

        // Reset in the middle of a note.
        wr(0, 4, 2, 0);
        idle(3);
        step(1, 0, 0, 0, 0, 0, 2'b00);
        idle(3);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            logic [1:0] stp;
            stp = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            if ($urandom_range(0, 7) == 0)
                step(0, 1, $urandom_range(0, 3), $urandom_range(0, 12),
                     $urandom_range(0, 14), $urandom_range(0, 4), stp);
            else
                step(0, 0, 0, 0, 0, 0, stp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tone_gen.md
# tone_gen

Parametrised multi-channel tone generator that succeeds the single-channel square-wave buzzer driver. Each channel produces a programmable-period, programmable-duty PWM tone for a programmable duration measured in prescaled ticks, with per-channel busy/done status. Sits behind the MMIO peripheral decoder and drives the board buzzer pin (via `mix`) or external audio pins (via `tone`).

## Interface
- `CLK_HZ`, 50_000_000: clk frequency in Hz.
- `TICK_HZ`, 1000: duration tick rate in Hz; `TICK_DIV = CLK_HZ / TICK_HZ` must be ≥ 2.
- `CHANNELS`, 2: number of independent channels, 1..8.
- `CHW`, 1: width of the channel index; 2^CHW ≥ CHANNELS.
- `PW`, 32: period/duty width in clk cycles.
- `DW`, 16: duration width in ticks.

- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `wr_en` in 1: load the note in `wr_period`/`wr_duty`/`wr_dur` into channel `wr_ch`.
- `wr_ch` in CHW: target channel. An index ≥ CHANNELS is ignored.
- `wr_period` in PW: full tone period in clk cycles.
- `wr_duty` in PW: high cycles per period.
- `wr_dur` in DW: note length in ticks; 0 means play until stopped.
- `stop_mask` in CHANNELS: a 1 in bit i stops channel i.
- `tone` out CHANNELS: per-channel registered tone output.
- `mix` out 1: registered OR of all `tone` bits.
- `busy` out CHANNELS: channel is in PLAY.
- `done` out CHANNELS: one-cycle pulse when a finite note expires naturally.

## Operation
- Prescaler: free-running counter `0..TICK_DIV-1`, shared by all channels.
  - Internal `tick` is high in the cycle the count equals `TICK_DIV-1`.
  - Not restarted by writes, so a finite note lasts between `(wr_dur-1)*TICK_DIV+1` and `wr_dur*TICK_DIV` cycles.
- Per-channel FSM:
  - IDLE: `tone=0`, `busy=0`.
  - A write moves the channel to PLAY. It latches period, duty and duration, and sets phase to 0.
- Write with `wr_period < 2` is a stop command: the channel goes to IDLE, with no `done`.
- PLAY:
  - Phase counts 0..period-1, then wraps to 0.
  - `tone` is high when phase < duty.
  - `duty = 0` gives a silent timed rest. `duty ≥ period` gives constant high.
- Duration, when the latched duration ≠ 0:
  - The duration counter decrements on each `tick`.
  - On the tick that moves it from 1 to 0, the channel goes to IDLE and `done` pulses for one cycle.
- Retrigger: a write to a channel in PLAY reloads all parameters and restarts the phase. No `done` is issued for the interrupted note.
- `stop_mask` bit set: the channel goes to IDLE, with no `done`.
- Priority within a channel in one cycle:
  - Write beats stop.
  - Write beats natural expiry; no `done` in that case.
  - Stop beats expiry; no `done` in that case.
- Channels are fully independent. Only one write per cycle.
- Reset:
  - Prescaler = 0.
  - All channels IDLE.
  - All phase and duration counters = 0.
  - `tone`, `mix`, `busy`, `done` all 0.
  - `rst` mid-note silences the channel at the next edge, with no `done`.

## Timing
- All outputs are registered.
- Write at edge T:
  - From T+1: `busy=1`, phase=0, `tone = (duty≠0)`.
  - `tone` then repeats with period exactly P cycles, high for exactly min(D,P) cycles per period.
- `mix` is derived from `tone`, registered in the same cycle: `mix(t) = |tone(t)`.
- Expiry:
  - If the tick at edge E takes the count 1→0, then from E+1: `busy=0`, `tone=0`, `done=1`.
  - `done=0` again at E+2.
- Stop at edge S: from S+1, `busy=0` and `tone=0`.
- Counter widths:
  - Phase counter is PW bits; it never overflows since it wraps at period-1.
  - Duration counter is DW bits; its maximum is 2^DW-1 ticks.

## Test plan
Bench uses `CLK_HZ=1000`, `TICK_HZ=100` (`TICK_DIV=10`), `CHANNELS=2`, `PW=8`, `DW=8`.
- Reset check: assert `rst` 3 cycles, with `wr_en` held high during reset. Required: all outputs 0 and the channel stays IDLE after reset is released.
- Basic note: `wr_ch=0`, period=4, duty=1, dur=3, written the cycle the prescaler = 0. Required:
  - `tone[0]` pattern 1000 repeating.
  - `busy[0]` high exactly 30 cycles, then `done[0]` for one cycle.
- Duty extremes:
  - period=5, duty=0: `tone` stays 0, `busy` stays 1.
  - period=5, duty=9: `tone` stays 1.
  - dur=0: no `done` after 300 cycles.
- Retrigger and stop:
  - During ch0 note (period=6, duty=3), write period=2, duty=1. Required: `tone` restarts at phase 0 and toggles every cycle, with no `done`.
  - Then `stop_mask=01`. Required: `busy[0]=0` next cycle.
- Two channels and mix:
  - ch0 period=4, duty=2, dur=2; ch1 period=6, duty=1, dur=4. Required: `mix` equals the OR of the two patterns, and `done[0]` and `done[1]` pulse at distinct, correct cycles.
- Collisions:
  - Write ch1 in the same cycle as its expiry tick: no `done[1]`, new note plays.
  - `stop_mask=10` with a write to ch1 in the same cycle: the write wins.
  - Write with period=1: the channel goes IDLE.
  - `wr_ch=3` (≥ CHANNELS): ignored.
